// File: rtl/muldiv_issue_ctrl.sv
// Issue-side controller for the mul/div unit: one-entry request holding register, credit-guarded result FIFO.
// Latency: request fires the cycle after capture at the earliest; results appear on wb_* the cycle after return.
// Backpressure: req_ready_o drops while a request is pending; fire waits for a free result credit and, for divides, fu_ready_i.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              kills the pending request, in-flight multiplies and buffered results
//   req_*                issue-side request (valid/ready handshake)
//   fu_*                 request to the unit; fu_ready_i only gates divides
//   res_*                unit results; no backpressure towards the unit
//   wb_*                 writeback from the result FIFO head (valid/ready)
//   busy_o, proto_err_o  activity indicator, sticky unexpected/missing-result flag
module muldiv_issue_ctrl #(
    parameter int XLEN      = 64,
    parameter int OP_W      = 8,
    parameter int TID_W     = 3,
    parameter int MUL_LAT   = 2,
    parameter int RES_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_is_div_i,
    input  logic [OP_W-1:0]  req_op_i,
    input  logic [TID_W-1:0] req_tid_i,
    input  logic [XLEN-1:0]  req_a_i,
    input  logic [XLEN-1:0]  req_b_i,
    output logic             fu_valid_o,
    output logic [OP_W-1:0]  fu_op_o,
    output logic [TID_W-1:0] fu_tid_o,
    output logic [XLEN-1:0]  fu_a_o,
    output logic [XLEN-1:0]  fu_b_o,
    input  logic             fu_ready_i,
    input  logic             res_valid_i,
    input  logic [TID_W-1:0] res_tid_i,
    input  logic [XLEN-1:0]  res_data_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [TID_W-1:0] wb_tid_o,
    output logic [XLEN-1:0]  wb_data_o,
    output logic             busy_o,
    output logic             proto_err_o
);

    localparam int PTR_W = $clog2(RES_DEPTH);
    // Wide enough for FIFO occupancy + every multiply stage + one divide.
    localparam int CNT_W = $clog2(RES_DEPTH + MUL_LAT + 2);

    typedef enum logic {
        EMPTY = 1'b0,
        PEND  = 1'b1
    } state_e;

    typedef struct packed {
        logic             is_div;
        logic [OP_W-1:0]  op;
        logic [TID_W-1:0] tid;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
    } hold_t;

    typedef struct packed {
        logic [TID_W-1:0] tid;
        logic [XLEN-1:0]  data;
    } res_t;

    state_e               state_q, state_d;
    hold_t                hold_q, hold_d;
    logic [MUL_LAT-1:0]   live_q, live_d, killed_q, killed_d;
    logic                 div_inflight_q, div_inflight_d;
    logic                 proto_err_q, proto_err_d;
    res_t                 mem_q [RES_DEPTH];
    logic [PTR_W-1:0]     wptr_q, rptr_q;
    logic [PTR_W:0]       cnt_q;

    logic                 fire, mul_fire, div_fire, credit_ok;
    logic                 tap_live, tap_killed, tap_any;
    logic                 push, pop, div_done, missing, unexpected;
    logic [CNT_W-1:0]     used;

    // Every op that will return a result holds a credit until it leaves the FIFO,
    // so a returning result always finds a free slot.
    always_comb begin
        used = CNT_W'(cnt_q) + CNT_W'(div_inflight_q);
        for (int i = 0; i < MUL_LAT; i++) begin
            used = used + CNT_W'(live_q[i]);
        end
    end

    assign credit_ok   = used < CNT_W'(RES_DEPTH);
    assign fu_valid_o  = (state_q == PEND) && credit_ok && !flush_i;
    assign fire        = fu_valid_o && (!hold_q.is_div || (fu_ready_i && !div_inflight_q));
    assign mul_fire    = fire && !hold_q.is_div;
    assign div_fire    = fire && hold_q.is_div;
    assign req_ready_o = !flush_i && ((state_q == EMPTY) || fire);

    assign fu_op_o  = hold_q.op;
    assign fu_tid_o = hold_q.tid;
    assign fu_a_o   = hold_q.a;
    assign fu_b_o   = hold_q.b;

    // Holding register next state.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else if (req_valid_i && req_ready_o) begin
            state_d = PEND;
            hold_d  = '{is_div: req_is_div_i, op: req_op_i, tid: req_tid_i,
                        a: req_a_i, b: req_b_i};
        end else if (fire) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    assign tap_live   = live_q[MUL_LAT-1];
    assign tap_killed = killed_q[MUL_LAT-1];
    assign tap_any    = tap_live || tap_killed;

    // Multiply results win over divide results, matching the unit's output
    // arbitration; killed multiplies still occupy their slot in time.
    always_comb begin
        live_d      = '0;
        killed_d    = '0;
        live_d[0]   = mul_fire;
        for (int i = 1; i < MUL_LAT; i++) begin
            live_d[i]   = live_q[i-1] && !flush_i;
            killed_d[i] = killed_q[i-1] || (live_q[i-1] && flush_i);
        end

        push       = 1'b0;
        div_done   = 1'b0;
        unexpected = 1'b0;
        if (res_valid_i && !flush_i) begin
            if (tap_any) begin
                push = tap_live;
            end else if (div_inflight_q) begin
                push     = 1'b1;
                div_done = 1'b1;
            end else begin
                unexpected = 1'b1;
            end
        end
        missing = !res_valid_i && tap_any;

        div_inflight_d = div_inflight_q;
        if (flush_i) begin
            div_inflight_d = 1'b0;
        end else if (div_fire) begin
            div_inflight_d = 1'b1;
        end else if (div_done) begin
            div_inflight_d = 1'b0;
        end

        proto_err_d = proto_err_q || missing || unexpected;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_q         <= '0;
            killed_q       <= '0;
            div_inflight_q <= 1'b0;
            proto_err_q    <= 1'b0;
        end else begin
            live_q         <= live_d;
            killed_q       <= killed_d;
            div_inflight_q <= div_inflight_d;
            proto_err_q    <= proto_err_d;
        end
    end

    // Result FIFO; pointers wrap naturally since the depth is a power of two.
    assign wb_valid_o = (cnt_q != '0);
    assign pop        = wb_valid_o && wb_ready_i;
    assign wb_tid_o   = mem_q[rptr_q].tid;
    assign wb_data_o  = mem_q[rptr_q].data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < RES_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= '{tid: res_tid_i, data: res_data_i};
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            cnt_q <= cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    assign busy_o      = (state_q == PEND) || wb_valid_o || (|live_q) || (|killed_q) || div_inflight_q;
    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
module tb_muldiv_issue_ctrl;

    localparam int XLEN      = 64;
    localparam int OP_W      = 8;
    localparam int TID_W     = 3;
    localparam int MUL_LAT   = 2;
    localparam int RES_DEPTH = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             flush_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic             req_is_div_i;
    logic [OP_W-1:0]  req_op_i;
    logic [TID_W-1:0] req_tid_i;
    logic [XLEN-1:0]  req_a_i, req_b_i;
    logic             fu_valid_o;
    logic [OP_W-1:0]  fu_op_o;
    logic [TID_W-1:0] fu_tid_o;
    logic [XLEN-1:0]  fu_a_o, fu_b_o;
    logic             fu_ready_i;
    logic             res_valid_i;
    logic [TID_W-1:0] res_tid_i;
    logic [XLEN-1:0]  res_data_i;
    logic             wb_valid_o;
    logic             wb_ready_i;
    logic [TID_W-1:0] wb_tid_o;
    logic [XLEN-1:0]  wb_data_o;
    logic             busy_o;
    logic             proto_err_o;

    muldiv_issue_ctrl #(
        .XLEN(XLEN), .OP_W(OP_W), .TID_W(TID_W), .MUL_LAT(MUL_LAT), .RES_DEPTH(RES_DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_is_div_i(req_is_div_i),
        .req_op_i(req_op_i), .req_tid_i(req_tid_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
        .fu_valid_o(fu_valid_o), .fu_op_o(fu_op_o), .fu_tid_o(fu_tid_o),
        .fu_a_o(fu_a_o), .fu_b_o(fu_b_o), .fu_ready_i(fu_ready_i),
        .res_valid_i(res_valid_i), .res_tid_i(res_tid_i), .res_data_i(res_data_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_tid_o(wb_tid_o), .wb_data_o(wb_data_o),
        .busy_o(busy_o), .proto_err_o(proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [TID_W-1:0] tid;
        logic [XLEN-1:0]  data;
    } exp_t;

    typedef struct packed {
        logic [31:0]      due;
        logic [TID_W-1:0] tid;
        logic [XLEN-1:0]  data;
    } ures_t;

    exp_t  sb_q[$];
    ures_t mul_q[$];
    int    wb_cyc_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mul_fire_cnt = 0;
    int div_fire_cnt = 0;
    int div_lat = 3;
    int div_due = 0;
    bit div_rdy_en = 1'b1;
    bit unit_div_busy = 1'b0;
    logic [TID_W-1:0] div_tid;
    logic [XLEN-1:0]  div_data;

    // unit model sampling state
    bit               u_mf, u_df, u_fl;
    logic [TID_W-1:0] u_t;
    logic [XLEN-1:0]  u_a, u_b;
    exp_t             m_e;

    assign fu_ready_i = div_rdy_en && !unit_div_busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic expect_wb(input logic [TID_W-1:0] tid, input logic [XLEN-1:0] data);
        sb_q.push_back('{tid: tid, data: data});
    endtask

    task automatic issue(input bit dv, input logic [TID_W-1:0] tid,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        bit acc;
        acc          = 1'b0;
        req_valid_i  = 1'b1;
        req_is_div_i = dv;
        req_op_i     = {dv, 4'b0000, tid};
        req_tid_i    = tid;
        req_a_i      = a;
        req_b_i      = b;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk_i);
            acc = req_ready_o;
            @(posedge clk_i);
            #1;
        end
        req_valid_i = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: tid %0d not accepted, expected acceptance", tid);
        end
    endtask

    task automatic wait_idle(input string name);
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 80 && !idle; n++) begin
            @(negedge clk_i);
            idle = !busy_o;
            @(posedge clk_i);
            #1;
        end
        chk(name, idle, 1'b1);
    endtask

    // Behavioural mul/div unit: fixed-latency multiplier, one-deep divider,
    // multiply results take precedence on the shared result port.
    initial begin
        res_valid_i = 1'b0;
        res_tid_i   = '0;
        res_data_i  = '0;
        forever begin
            @(negedge clk_i);
            u_mf = rst_ni && fu_valid_o && !fu_op_o[7];
            u_df = rst_ni && fu_valid_o && fu_op_o[7] && fu_ready_i;
            u_fl = flush_i;
            u_t  = fu_tid_o;
            u_a  = fu_a_o;
            u_b  = fu_b_o;
            if (u_mf) begin
                mul_fire_cnt++;
                mul_q.push_back('{due: 32'(cyc + MUL_LAT), tid: u_t, data: u_a * u_b});
            end
            @(posedge clk_i);
            #1;
            cyc++;
            res_valid_i = 1'b0;
            if (!rst_ni) begin
                mul_q.delete();
                unit_div_busy = 1'b0;
            end else begin
                if (u_df) begin
                    div_fire_cnt++;
                    unit_div_busy = 1'b1;
                    div_due       = cyc - 1 + div_lat;
                    div_tid       = u_t;
                    div_data      = u_a / u_b;
                end
                if (u_fl) unit_div_busy = 1'b0;
                if (mul_q.size() > 0 && mul_q[0].due == 32'(cyc)) begin
                    res_valid_i = 1'b1;
                    res_tid_i   = mul_q[0].tid;
                    res_data_i  = mul_q[0].data;
                    void'(mul_q.pop_front());
                end else if (unit_div_busy && div_due <= cyc) begin
                    res_valid_i   = 1'b1;
                    res_tid_i     = div_tid;
                    res_data_i    = div_data;
                    unit_div_busy = 1'b0;
                end
            end
        end
    end

    // Writeback monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni && wb_valid_o && wb_ready_i) begin
                wb_cyc_q.push_back(cyc);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: got tid %0d data 0x%0h, expected no writeback", wb_tid_o, wb_data_o);
                end else begin
                    m_e = sb_q.pop_front();
                    chk("wb_tid", 64'(wb_tid_o), 64'(m_e.tid));
                    chk("wb_data", wb_data_o, m_e.data);
                end
            end
        end
    end

    initial begin
        repeat (10000) @(posedge clk_i);
        errors++;
        $display("FAIL watchdog: simulation still running, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int m0, d0;
        rst_ni       = 1'b0;
        flush_i      = 1'b0;
        req_valid_i  = 1'b0;
        req_is_div_i = 1'b0;
        req_op_i     = '0;
        req_tid_i    = '0;
        req_a_i      = '0;
        req_b_i      = '0;
        wb_ready_i   = 1'b1;
        step(3);

        // Reset state
        @(negedge clk_i);
        chk("rst_fu_valid", fu_valid_o, 1'b0);
        chk("rst_wb_valid", wb_valid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_proto_err", proto_err_o, 1'b0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("idle_req_ready", req_ready_o, 1'b1);
        chk("idle_fu_valid", fu_valid_o, 1'b0);
        @(posedge clk_i); #1;

        // Multiply chain, back-to-back issue
        wb_cyc_q.delete();
        expect_wb(3'd1, 64'd15);
        expect_wb(3'd2, 64'd42);
        expect_wb(3'd3, 64'd300);
        issue(1'b0, 3'd1, 64'd3, 64'd5);
        issue(1'b0, 3'd2, 64'd6, 64'd7);
        issue(1'b0, 3'd3, 64'd100, 64'd3);
        wait_idle("mul_chain_idle");
        chk("mul_chain_pops", 64'(wb_cyc_q.size()), 64'd3);
        if (wb_cyc_q.size() >= 3) begin
            chk("mul_chain_gap1", 64'(wb_cyc_q[1] - wb_cyc_q[0]), 64'd1);
            chk("mul_chain_gap2", 64'(wb_cyc_q[2] - wb_cyc_q[1]), 64'd1);
        end

        // Divide stall
        div_rdy_en = 1'b0;
        div_lat    = 3;
        d0         = div_fire_cnt;
        expect_wb(3'd5, 64'h2A);
        issue(1'b1, 3'd5, 64'd84, 64'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            chk("div_stall_fu_valid", fu_valid_o, 1'b1);
            chk("div_stall_req_ready", req_ready_o, 1'b0);
            chk("div_stall_fu_op", 64'(fu_op_o), 64'h85);
            chk("div_stall_fu_tid", 64'(fu_tid_o), 64'd5);
            chk("div_stall_fu_a", fu_a_o, 64'd84);
            chk("div_stall_fu_b", fu_b_o, 64'd2);
            @(posedge clk_i); #1;
        end
        chk("div_stall_no_fire", 64'(div_fire_cnt - d0), 64'd0);
        div_rdy_en = 1'b1;
        wait_idle("div_idle");
        chk("div_fire_once", 64'(div_fire_cnt - d0), 64'd1);

        // Credit limit with writeback stalled
        wb_ready_i = 1'b0;
        m0 = mul_fire_cnt;
        for (int i = 1; i <= 5; i++) expect_wb(TID_W'(i), 64'(i * 10));
        for (int i = 1; i <= 5; i++) issue(1'b0, TID_W'(i), 64'(i), 64'd10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("credit_block_fu_valid", fu_valid_o, 1'b0);
            @(posedge clk_i); #1;
        end
        chk("credit_fifo_full", wb_valid_o, 1'b1);
        chk("credit_four_fired", 64'(mul_fire_cnt - m0), 64'd4);
        wb_ready_i = 1'b1;
        @(negedge clk_i);
        chk("credit_pop_cycle_fu_valid", fu_valid_o, 1'b0);
        @(posedge clk_i); #1;
        wb_ready_i = 1'b0;
        @(negedge clk_i);
        chk("credit_refire_fu_valid", fu_valid_o, 1'b1);
        @(posedge clk_i); #1;
        chk("credit_five_fired", 64'(mul_fire_cnt - m0), 64'd5);
        wb_ready_i = 1'b1;
        wait_idle("credit_idle");

        // Mixed precedence: multiply returns while divide is in flight
        div_lat = 6;
        expect_wb(3'd7, 64'd9);
        expect_wb(3'd6, 64'd25);
        issue(1'b1, 3'd6, 64'd100, 64'd4);
        issue(1'b0, 3'd7, 64'd3, 64'd3);
        wait_idle("mixed_idle");
        chk("mixed_proto_err", proto_err_o, 1'b0);

        // Flush with two multiplies in flight and a pending divide
        div_rdy_en = 1'b0;
        issue(1'b0, 3'd1, 64'd2, 64'd2);
        issue(1'b0, 3'd2, 64'd3, 64'd3);
        issue(1'b1, 3'd3, 64'd9, 64'd3);
        flush_i = 1'b1;
        @(negedge clk_i);
        chk("flush_req_ready", req_ready_o, 1'b0);
        chk("flush_fu_valid", fu_valid_o, 1'b0);
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        @(negedge clk_i);
        chk("flush_killed_busy", busy_o, 1'b1);
        chk("flush_wb_valid1", wb_valid_o, 1'b0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("flush_busy_clear", busy_o, 1'b0);
        chk("flush_wb_valid2", wb_valid_o, 1'b0);
        chk("flush_proto_err", proto_err_o, 1'b0);
        @(posedge clk_i); #1;
        div_rdy_en = 1'b1;
        step(4);
        @(negedge clk_i);
        chk("flush_later_busy", busy_o, 1'b0);
        chk("flush_later_proto", proto_err_o, 1'b0);
        @(posedge clk_i); #1;

        // Reset in the middle of operation
        wb_ready_i = 1'b0;
        div_lat    = 20;
        issue(1'b0, 3'd1, 64'd1, 64'd1);
        issue(1'b0, 3'd2, 64'd1, 64'd1);
        issue(1'b0, 3'd3, 64'd1, 64'd1);
        issue(1'b1, 3'd4, 64'd8, 64'd2);
        step(2);
        @(negedge clk_i);
        chk("prereset_wb_valid", wb_valid_o, 1'b1);
        chk("prereset_busy", busy_o, 1'b1);
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        #1;
        chk("midrst_fu_valid", fu_valid_o, 1'b0);
        chk("midrst_wb_valid", wb_valid_o, 1'b0);
        chk("midrst_wb_tid", 64'(wb_tid_o), 64'd0);
        chk("midrst_wb_data", wb_data_o, 64'd0);
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_proto_err", proto_err_o, 1'b0);
        step(2);
        rst_ni = 1'b1;
        @(negedge clk_i);
        mul_q.push_back('{due: 32'(cyc + 1), tid: 3'd6, data: 64'h55});
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("stray_res_wb_valid", wb_valid_o, 1'b0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("stray_res_proto_err", proto_err_o, 1'b1);
        chk("stray_res_wb_valid2", wb_valid_o, 1'b0);
        chk("stray_res_busy", busy_o, 1'b0);
        @(posedge clk_i); #1;

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
- Initiator-side controller for the mul/div functional unit. It sits between the issue stage and the unit.
- Holds one issued request and presents it to the unit with the unit's valid/ready rules: multiply is always accepted, divide only when the unit is ready.
- Tracks in-flight operations and classifies returning results as multiply or divide. Results are buffered in a credit-guarded FIFO because the unit has no result backpressure.
- Handles flush by killing in-flight multiplies and dropping the pending request.

Parameters:
- XLEN, 64, operand/result width
- OP_W, 8, width of the opaque operation code forwarded to the unit
- TID_W, 3, transaction ID width
- MUL_LAT, 2, fixed cycles from multiply fire to result valid (≥1)
- RES_DEPTH, 4, result FIFO depth and credit limit (power of 2, ≥2)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset (see Behaviour)
- flush_i  in  1  kill pending and in-flight work
- req_valid_i  in  1  issue request valid
- req_ready_o  out  1  controller can take a request
- req_is_div_i  in  1  request is DIV/DIVU/REM/REMU (any width variant)
- req_op_i  in  OP_W  operation code
- req_tid_i  in  TID_W  transaction ID
- req_a_i, req_b_i  in  XLEN  operands
- fu_valid_o  out  1  request valid to unit
- fu_op_o  out  OP_W  operation code to unit
- fu_tid_o  out  TID_W  transaction ID to unit
- fu_a_o, fu_b_o  out  XLEN  operands to unit
- fu_ready_i  in  1  unit divider ready
- res_valid_i  in  1  unit result valid
- res_tid_i  in  TID_W  unit result transaction ID
- res_data_i  in  XLEN  unit result data
- wb_valid_o  out  1  writeback valid (FIFO head)
- wb_ready_i  in  1  writeback consumer accepts
- wb_tid_o  out  TID_W  writeback transaction ID
- wb_data_o  out  XLEN  writeback data
- busy_o  out  1  any pending, in-flight or buffered op
- proto_err_o  out  1  sticky: unexpected result seen

Behaviour:
- Reset: rst_ni, asynchronous, active-low; clock clk_i.
- After reset: all valids 0, FIFO empty, holding register empty, shift register cleared, div_inflight 0, proto_err_o 0, busy_o 0.
- Holding register (state EMPTY/PEND):
  - Captures req_* when req_valid_i && req_ready_o.
  - req_ready_o = EMPTY || fire_this_cycle. Back-to-back issue at 1 op/cycle is allowed.
  - fu_valid_o = PEND && credit_ok && !flush_i. fu_* are driven directly from the holding register.
- Fire conditions:
  - Fire = fu_valid_o && (!is_div || (fu_ready_i && !div_inflight)).
  - Multiply fire: shift register entry 0 is set to {live=1}.
  - Divide fire: div_inflight is set.
  - PEND→EMPTY on fire unless a new request is captured in the same cycle (stays PEND).
- Credits:
  - used = fifo_count + live multiply entries in the shift register + div_inflight.
  - credit_ok = used < RES_DEPTH. This guarantees every returning result has a FIFO slot.
- Shift register: MUL_LAT entries with {live, killed}, advancing every cycle. Tap = entry MUL_LAT-1.
- Result classification when res_valid_i:
  - Tap live or killed → multiply result. Multiply has precedence, consistent with the unit's output arbitration. Push to the FIFO if live; drop if killed.
  - Otherwise, if div_inflight → divide result: push, clear div_inflight.
  - Otherwise → drop and set proto_err_o.
- Tap live/killed with res_valid_i=0 → set proto_err_o (latency mismatch).
- FIFO:
  - Push as classified above.
  - Pop on wb_valid_o && wb_ready_i.
  - Push and pop in the same cycle are both allowed, including when full (the pop frees the slot).
  - wb_* is the head entry, registered storage. Write-pointer wrap is modulo RES_DEPTH.
- Flush (flush_i=1, effective that cycle):
  - No fire; holding register → EMPTY; req_ready_o=0.
  - FIFO cleared; div_inflight cleared (the unit's divider drops its op on flush).
  - All live shift entries become killed. Killed entries still advance and their results are dropped silently.
  - A result arriving in the flush cycle is discarded.
- busy_o = PEND || fifo_count≠0 || any live/killed entry || div_inflight.

Test Plan:
- Multiply chain, MUL_LAT=2: issue tids 1,2,3 on consecutive cycles, unit returns each 2 cycles after its fire, wb_ready_i=1 → wb tids 1,2,3 in order, one per cycle, no stall.
- Divide stall: div tid 5 with fu_ready_i=0 for 10 cycles → fu_valid_o held high with stable fu_*, req_ready_o=0. After fu_ready_i=1 → one fire. A result with data 0x2A → wb tid 5, data 0x2A.
- Credit full, RES_DEPTH=4: wb_ready_i=0, issue 5 multiplies → 4 fire, 5th holds fu_valid_o=0 until one wb pop. After the pop it fires the next cycle.
- Mixed precedence: div in flight, multiply fired; multiply result returns at the tap → classified as multiply. Div result later → classified as divide. Both tids are written back correctly.
- Flush: 2 multiplies in flight plus one pending div, pulse flush_i → both multiply results dropped, FIFO empty, proto_err_o=0, busy_o=0 after MUL_LAT cycles.
- Reset mid-operation: assert rst_ni=0 with the FIFO holding 3 entries and a div in flight → all outputs 0 immediately. A res_valid_i after reset is deasserted → dropped, proto_err_o=1.
